// File: rtl/pipeline_perf_pkg.sv
// Shared encodings for the pipeline performance monitor: FSM states and the
// shadow-counter address map.
package pipeline_perf_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam int ADDR_CYCLE  = 0;
  localparam int ADDR_RETIRE = 1;

  function automatic int stall_addr(input int idx);
    return 2 + idx;
  endfunction

  function automatic int flush_addr(input int num_stages, input int idx);
    return 2 + num_stages + idx;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module perf_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 sat
);

  assign sat = &value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en && inc && !sat) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Cycle/retire/stall/flush performance monitor with atomic shadow snapshot and
// registered read port. Optional retire watchdog: PERF_MON_WATCHDOG_EN.
module pipeline_perf_monitor
  import pipeline_perf_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  clear,
  input  logic                                  halt,
  input  logic                                  retire_valid,
  input  logic [NUM_STAGES-1:0]                 stage_stall,
  input  logic [NUM_STAGES-1:0]                 stage_flush,
  input  logic                                  snap_req,
  output logic                                  snap_done,
  input  logic                                  rd_en,
  input  logic [$clog2(2+2*NUM_STAGES)-1:0]     rd_addr,
  output logic [CNT_WIDTH-1:0]                  rd_data,
  output logic                                  rd_valid,
  output logic [1:0]                            state,
  output logic                                  sat_flag,
  output logic                                  hang_flag
);

  localparam int NUM_CNT = 2 + 2 * NUM_STAGES;

  logic [NUM_CNT-1:0]   inc_vec;
  logic [NUM_CNT-1:0]   sat_vec;
  logic [CNT_WIDTH-1:0] live   [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow [NUM_CNT];
  logic                 running;
  logic                 trip;
  logic [1:0]           state_next;

  assign running = (state == RUN);

  always_comb begin
    inc_vec              = '0;
    inc_vec[ADDR_CYCLE]  = 1'b1;
    inc_vec[ADDR_RETIRE] = retire_valid;
    for (int i = 0; i < NUM_STAGES; i++) begin
      inc_vec[stall_addr(i)]             = stage_stall[i];
      inc_vec[flush_addr(NUM_STAGES, i)] = stage_flush[i];
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (clear),
      .en    (running),
      .inc   (inc_vec[g]),
      .value (live[g]),
      .sat   (sat_vec[g])
    );
  end

  // Counters only return to zero through clear/reset, so any counter at
  // all-ones is exactly the sticky saturation condition.
  assign sat_flag = |sat_vec;

`ifdef PERF_MON_WATCHDOG_EN
  localparam int GAP_W = $clog2(WDOG_LIMIT + 1);

  logic [GAP_W-1:0] gap;
  logic             hang;

  assign trip      = running && (gap >= GAP_W'(WDOG_LIMIT));
  assign hang_flag = hang;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap  <= '0;
      hang <= 1'b0;
    end else if (clear) begin
      gap  <= '0;
      hang <= 1'b0;
    end else begin
      if (running) begin
        if (retire_valid)  gap <= '0;
        else if (!trip)    gap <= gap + 1'b1;
      end
      if (trip) hang <= 1'b1;
    end
  end
`else
  assign trip      = 1'b0;
  assign hang_flag = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (halt || trip) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Shadow captures the pre-edge live values, so a snapshot coinciding with
  // clear keeps the old counts; reads see the shadow before this edge's capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
      snap_done <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      snap_done <= snap_req;
      if (snap_req) begin
        for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
      end
      rd_valid <= rd_en;
      if (rd_en && (int'(rd_addr) < NUM_CNT)) rd_data <= shadow[rd_addr];
      else                                    rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Self-checking bench for pipeline_perf_monitor: directed scenarios plus a
// randomized run against a cycle-level reference model of counters and shadow.
module tb_pipeline_perf_monitor;

  localparam int N    = 5;
  localparam int W    = 8;
  localparam int LIM  = 16;
  localparam int NC   = 2 + 2 * N;
  localparam int MAXV = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, clear, halt, retire_valid, snap_req, rd_en;
  logic [N-1:0] stage_stall, stage_flush;
  logic [3:0]   rd_addr;
  logic         snap_done, rd_valid, sat_flag, hang_flag;
  logic [W-1:0] rd_data;
  logic [1:0]   state;

  int errors = 0;
  int checks = 0;

  // reference model
  int m_live   [NC];
  int m_shadow [NC];
  int m_state;
  int m_rd_data;
  bit m_rd_valid, m_snap_done, m_hang;
  int m_gap;

  always #5 clock = ~clock;

  pipeline_perf_monitor #(.NUM_STAGES(N), .CNT_WIDTH(W), .WDOG_LIMIT(LIM)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .clear        (clear),
    .halt         (halt),
    .retire_valid (retire_valid),
    .stage_stall  (stage_stall),
    .stage_flush  (stage_flush),
    .snap_req     (snap_req),
    .snap_done    (snap_done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .state        (state),
    .sat_flag     (sat_flag),
    .hang_flag    (hang_flag)
  );

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_live[i]   = 0;
      m_shadow[i] = 0;
    end
    m_state = 0; m_rd_data = 0; m_rd_valid = 0; m_snap_done = 0; m_hang = 0; m_gap = 0;
  endtask

  function automatic bit model_sat();
    bit s = 0;
    for (int i = 0; i < NC; i++) if (m_live[i] == MAXV) s = 1;
    return s;
  endfunction

  function automatic int bump(input int v, input bit c);
    return (c && v < MAXV) ? v + 1 : v;
  endfunction

  // One clock edge of the monitor, from the inputs currently applied.
  task automatic model_step();
    int  old [NC];
    bit  tripped;
    for (int i = 0; i < NC; i++) old[i] = m_live[i];
    m_rd_valid  = rd_en;
    m_rd_data   = (rd_en && int'(rd_addr) < NC) ? m_shadow[rd_addr] : 0;
    m_snap_done = snap_req;
    if (snap_req) for (int i = 0; i < NC; i++) m_shadow[i] = old[i];
    tripped = 0;
    if (clear) begin
      for (int i = 0; i < NC; i++) m_live[i] = 0;
      m_state = 0; m_gap = 0; m_hang = 0;
    end else begin
      if (m_state == 1) begin
        m_live[0] = bump(old[0], 1'b1);
        m_live[1] = bump(old[1], retire_valid);
        for (int i = 0; i < N; i++) begin
          m_live[2 + i]     = bump(old[2 + i], stage_stall[i]);
          m_live[2 + N + i] = bump(old[2 + N + i], stage_flush[i]);
        end
      end
`ifdef PERF_MON_WATCHDOG_EN
      tripped = (m_state == 1) && (m_gap >= LIM);
      if (m_state == 1) m_gap = retire_valid ? 0 : ((m_gap < LIM) ? m_gap + 1 : m_gap);
      if (tripped) m_hang = 1;
`endif
      if (m_state == 0 && start) m_state = 1;
      else if (m_state == 1 && (halt || tripped)) m_state = 2;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; clear = 0; halt = 0; retire_valid = 0; snap_req = 0; rd_en = 0;
    stage_stall = '0; stage_flush = '0; rd_addr = '0;
  endtask

  task automatic do_clear_start();
    clear = 1; tick(); clear = 0;
    start = 1; tick(); start = 0;
  endtask

  task automatic do_snap();
    snap_req = 1; tick(); snap_req = 0;
  endtask

  task automatic read_addr(input int a, output logic [W-1:0] d, output logic v);
    rd_en = 1; rd_addr = 4'(a);
    tick();
    d = rd_data; v = rd_valid;
    rd_en = 0;
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    logic         v;
    idle_inputs();
    reset = 1;
    model_reset();
    #3;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (snap_done !== 1'b0) begin errors++; $display("FAIL reset_snap_done: got %b want 0", snap_done); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
    checks++; if (hang_flag !== 1'b0) begin errors++; $display("FAIL reset_hang_flag: got %b want 0", hang_flag); end
    @(negedge clock);
    reset = 0;
    tick();
    for (int a = 0; a < NC; a++) begin
      read_addr(a, d, v);
      checks++; if (v !== 1'b1 || d !== '0) begin errors++; $display("FAIL reset_shadow[%0d]: got %0d valid %b want 0 valid 1", a, d, v); end
    end
  endtask

  task automatic test_count_retire();
    logic [9:0]   pat = 10'b1011010110;
    logic [W-1:0] d;
    logic         v;
    do_clear_start();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", state); end
    for (int i = 0; i < 10; i++) begin
      retire_valid = pat[i];
      tick();
    end
    retire_valid = 0;
    do_snap();
    checks++; if (snap_done !== 1'b1) begin errors++; $display("FAIL snap_done_pulse: got %b want 1", snap_done); end
    tick();
    checks++; if (snap_done !== 1'b0) begin errors++; $display("FAIL snap_done_clear: got %b want 0", snap_done); end
    read_addr(0, d, v);
    checks++; if (d !== 8'd10 || v !== 1'b1) begin errors++; $display("FAIL cycle_cnt_10: got %0d want 10", d); end
    read_addr(1, d, v);
    checks++; if (d !== 8'd6) begin errors++; $display("FAIL retired_cnt_6: got %0d want 6", d); end
  endtask

  task automatic test_stall_flush();
    logic [W-1:0] d;
    logic         v;
    do_clear_start();
    for (int i = 0; i < 3; i++) begin
      stage_stall = 5'b00010;
      stage_flush = (i == 1) ? 5'b00100 : 5'b00000;
      tick();
    end
    stage_stall = '0; stage_flush = '0;
    tick();
    do_snap();
    read_addr(3, d, v);
    checks++; if (d !== 8'd3) begin errors++; $display("FAIL stall_cnt1: got %0d want 3", d); end
    read_addr(9, d, v);
    checks++; if (d !== 8'd1) begin errors++; $display("FAIL flush_cnt2: got %0d want 1", d); end
    read_addr(2, d, v);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL stall_cnt0: got %0d want 0", d); end
    read_addr(12, d, v);
    checks++; if (d !== 8'd0 || v !== 1'b1) begin errors++; $display("FAIL out_of_range: got %0d valid %b want 0 valid 1", d, v); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] d;
    logic         v;
    do_clear_start();
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_before: got %b want 0", sat_flag); end
    retire_valid = 1;
    for (int i = 0; i < 300; i++) tick();
    retire_valid = 0;
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
    do_snap();
    read_addr(0, d, v);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL cycle_saturate: got %0h want ff", d); end
    read_addr(1, d, v);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL retire_saturate: got %0h want ff", d); end
    clear = 1; tick(); clear = 0;
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_cleared: got %b want 0", sat_flag); end
  endtask

  task automatic test_halt_clear();
    logic [W-1:0] d;
    logic         v;
    do_clear_start();
    for (int i = 1; i <= 5; i++) begin
      retire_valid = 1;
      halt = (i == 5);
      tick();
    end
    halt = 0;
    for (int i = 0; i < 4; i++) tick();
    retire_valid = 0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL halted_state: got %0d want 2", state); end
    start = 1; tick(); start = 0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL start_ignored: got %0d want 2", state); end
    do_snap();
    read_addr(0, d, v);
    checks++; if (d !== 8'd5) begin errors++; $display("FAIL halt_cycle_cnt: got %0d want 5", d); end
    clear = 1; snap_req = 1; halt = 1;
    tick();
    clear = 0; snap_req = 0; halt = 0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL clear_to_idle: got %0d want 0", state); end
    read_addr(0, d, v);
    checks++; if (d !== 8'd5) begin errors++; $display("FAIL clear_snap_shadow: got %0d want 5", d); end
    do_snap();
    read_addr(0, d, v);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL clear_live_zero: got %0d want 0", d); end
  endtask

  task automatic test_watchdog();
    do_clear_start();
    for (int i = 0; i < 20; i++) tick();
`ifdef PERF_MON_WATCHDOG_EN
    checks++; if (hang_flag !== 1'b1) begin errors++; $display("FAIL wdog_hang: got %b want 1", hang_flag); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL wdog_state: got %0d want 2", state); end
`else
    checks++; if (hang_flag !== 1'b0) begin errors++; $display("FAIL wdog_hang: got %b want 0", hang_flag); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL wdog_state: got %0d want 1", state); end
`endif
  endtask

  task automatic test_back_to_back();
    do_clear_start();
    for (int i = 0; i < 7; i++) begin
      retire_valid = 1'($urandom_range(0, 1));
      stage_stall  = 5'($urandom);
      stage_flush  = 5'($urandom);
      tick();
    end
    retire_valid = 0; stage_stall = '0; stage_flush = '0;
    snap_req = 1; rd_en = 1; rd_addr = 4'd0;
    tick();
    snap_req = 0;
    checks++; if (rd_data !== W'(m_rd_data)) begin errors++; $display("FAIL read_during_snap: got %0d want %0d", rd_data, m_rd_data); end
    for (int a = 0; a < NC; a++) begin
      rd_addr = 4'(a);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== W'(m_rd_data)) begin
        errors++; $display("FAIL b2b_read[%0d]: got %0d valid %b want %0d", a, rd_data, rd_valid, m_rd_data);
      end
    end
    rd_en = 0;
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clear        = ($urandom_range(0, 99) < 2);
      start        = ($urandom_range(0, 99) < 10);
      halt         = ($urandom_range(0, 99) < 2);
      retire_valid = ($urandom_range(0, 99) < 60);
      stage_stall  = 5'($urandom);
      stage_flush  = 5'($urandom) & 5'($urandom);
      snap_req     = ($urandom_range(0, 99) < 10);
      rd_en        = ($urandom_range(0, 99) < 50);
      rd_addr      = 4'($urandom_range(0, 15));
      tick();
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state@%0d: got %0d want %0d", c, state, m_state); end
      checks++; if (sat_flag !== model_sat()) begin errors++; $display("FAIL rnd_sat@%0d: got %b want %b", c, sat_flag, model_sat()); end
      checks++; if (snap_done !== m_snap_done) begin errors++; $display("FAIL rnd_snap_done@%0d: got %b want %b", c, snap_done, m_snap_done); end
      checks++; if (hang_flag !== m_hang) begin errors++; $display("FAIL rnd_hang@%0d: got %b want %b", c, hang_flag, m_hang); end
      checks++;
      if (rd_valid !== m_rd_valid || (m_rd_valid && rd_data !== W'(m_rd_data))) begin
        errors++; $display("FAIL rnd_read@%0d: got %0d valid %b want %0d valid %b", c, rd_data, rd_valid, m_rd_data, m_rd_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] d;
    logic         v;
    time          t_edge;
    do_clear_start();
    retire_valid = 1;
    for (int i = 0; i < 7; i++) tick();
    retire_valid = 0;
    snap_req = 1; rd_en = 1; rd_addr = 4'd0;
    tick();
    snap_req = 0; rd_en = 0;
    checks++; if (snap_done !== 1'b1 || rd_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_active: got snap %b valid %b want 1 1", snap_done, rd_valid); end
    t_edge = $time;
    #3;
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (state !== 2'd0 || snap_done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 || sat_flag !== 1'b0 || hang_flag !== 1'b0 || ($time - t_edge) >= 9) begin
      errors++; $display("FAIL async_reset: got state %0d snap %b valid %b data %0d sat %b hang %b want all 0", state, snap_done, rd_valid, rd_data, sat_flag, hang_flag);
    end
    #2;
    reset = 0;
    tick();
    do_snap();
    read_addr(0, d, v);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL reset_live_cycle: got %0d want 0", d); end
    read_addr(1, d, v);
    checks++; if (d !== 8'd0) begin errors++; $display("FAIL reset_live_retire: got %0d want 0", d); end
  endtask

  initial begin
    test_reset();
    test_count_retire();
    test_stall_flush();
    test_saturation();
    test_halt_clear();
    test_watchdog();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
